// File: rtl/bp_fe_bht_update_queue.sv
// BHT update queue: buffers branch resolutions and drains one {idx, correct} write per cycle,
// deferring on read/write index collisions up to max_stall_p cycles. Optional: BP_FE_BHT_UPD_DROP_OLDEST_EN.
module bp_fe_bht_update_queue #(
  parameter int bht_idx_width_p = 9,
  parameter int els_p           = 8,
  parameter int max_stall_p     = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         br_v_i,
  output logic                         br_ready_o,
  input  logic [bht_idx_width_p-1:0]   br_idx_i,
  input  logic                         br_taken_i,
  input  logic                         br_pred_i,
  input  logic                         r_v_i,
  input  logic [bht_idx_width_p-1:0]   idx_r_i,
  output logic                         w_v_o,
  output logic [bht_idx_width_p-1:0]   idx_w_o,
  output logic                         correct_o,
`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
  output logic [15:0]                  drop_cnt_o,
`endif
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int AW = $clog2(els_p);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(els_p + 1);
  localparam int SW = $clog2(max_stall_p + 1);

  logic [bht_idx_width_p-1:0] r_mem_idx [els_p];
  logic [els_p-1:0]           r_mem_correct;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [SW-1:0]              r_stall;

  logic                       w_empty;
  logic                       w_full;
  logic                       w_conf;
  logic                       w_force;
  logic                       w_pop;
  logic                       w_enq;
  logic                       w_drop;
  logic [bht_idx_width_p-1:0] w_head_idx;
  logic                       w_head_correct;

  assign w_empty        = (r_wptr == r_rptr);
  assign w_full         = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head_idx     = r_mem_idx[r_rptr[AW-1:0]];
  assign w_head_correct = r_mem_correct[r_rptr[AW-1:0]];
  assign w_conf         = ~w_empty & r_v_i & (idx_r_i == w_head_idx);
  assign w_force        = (r_stall == SW'(max_stall_p));
  assign w_pop          = ~w_empty & ~flush_i & (~w_conf | w_force);
  assign count_o        = CW'(r_wptr - r_rptr);

`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
  // When full, a new record evicts the oldest unless the head is leaving anyway.
  assign br_ready_o = reset_n_i;
  assign w_enq      = br_v_i & br_ready_o & ~flush_i;
  assign w_drop     = w_enq & w_full & ~w_pop;
`else
  assign br_ready_o = reset_n_i & ~w_full;
  assign w_enq      = br_v_i & br_ready_o & ~flush_i;
  assign w_drop     = 1'b0;
`endif

  // Write-port drive: head fields only while a write is issued, zero otherwise.
  always_comb begin
    w_v_o     = 1'b0;
    idx_w_o   = '0;
    correct_o = 1'b0;
    if (w_pop) begin
      w_v_o     = 1'b1;
      idx_w_o   = w_head_idx;
      correct_o = w_head_correct;
    end else begin
      w_v_o     = 1'b0;
    end
  end

  // Circular buffer storage and pointers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_mem_correct <= '0;
      for (int i = 0; i < els_p; i++) r_mem_idx[i] <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) begin
        r_mem_idx[r_wptr[AW-1:0]]     <= br_idx_i;
        r_mem_correct[r_wptr[AW-1:0]] <= ~(br_taken_i ^ br_pred_i);
        r_wptr                        <= r_wptr + PW'(1);
      end
      if (w_pop || w_drop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Consecutive-deferral counter; reaching max_stall_p forces the head out.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall <= '0;
    end else if (flush_i || w_pop || w_empty || w_drop) begin
      r_stall <= '0;
    end else if (w_conf && !w_force) begin
      r_stall <= r_stall + SW'(1);
    end else begin
      r_stall <= r_stall;
    end
  end

`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
  logic [15:0] r_drop_cnt;
  assign drop_cnt_o = r_drop_cnt;

  // Saturating count of evicted entries; only reset clears it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Directed bench for bp_fe_bht_update_queue: vector table plus multi-cycle sequences
// (starvation, fill/wrap, eviction when BP_FE_BHT_UPD_DROP_OLDEST_EN, async reset mid-drain).
module tb_bp_fe_bht_update_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       br_v;
  logic       br_ready;
  logic [8:0] br_idx;
  logic       br_taken;
  logic       br_pred;
  logic       r_v;
  logic [8:0] idx_r;
  logic       w_v;
  logic [8:0] idx_w;
  logic       correct;
  logic [3:0] count;
`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
  logic [15:0] drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_fe_bht_update_queue #(.bht_idx_width_p(9), .els_p(8), .max_stall_p(3)) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .flush_i    (flush),
    .br_v_i     (br_v),
    .br_ready_o (br_ready),
    .br_idx_i   (br_idx),
    .br_taken_i (br_taken),
    .br_pred_i  (br_pred),
    .r_v_i      (r_v),
    .idx_r_i    (idx_r),
    .w_v_o      (w_v),
    .idx_w_o    (idx_w),
    .correct_o  (correct),
`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
    .drop_cnt_o (drop_cnt),
`endif
    .count_o    (count)
  );

  typedef struct {
    int br_v; int idx; int tk; int pr; int r_v; int idx_r; int fl;
    int e_wv; int e_idx; int e_cor; int e_cnt; int e_rdy;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input int idx, input int tk, input int pr,
                       input int rv, input int ir, input int fl);
    br_v = v[0]; br_idx = 9'(idx); br_taken = tk[0]; br_pred = pr[0];
    r_v = rv[0]; idx_r = 9'(ir); flush = fl[0];
  endtask

  task automatic chk_out(input string name, input int ewv, input int eidx, input int ecor,
                         input int ecnt);
    chk({name, ".w_v"},     int'(w_v),     ewv);
    chk({name, ".idx_w"},   int'(idx_w),   eidx);
    chk({name, ".correct"}, int'(correct), ecor);
    chk({name, ".count"},   int'(count),   ecnt);
  endtask

  int a_idx[10];
  int exp_head;
  int exp_wv;
  int exp_cnt[10] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 7};

  initial begin
    vecs[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,1};
    vecs[1]  = '{1,5,1,1,0,0,0, 0,0,0,0,1};
    vecs[2]  = '{0,0,0,0,0,0,0, 1,5,1,1,1};
    vecs[3]  = '{0,0,0,0,0,0,0, 0,0,0,0,1};
    vecs[4]  = '{1,7,0,1,1,7,0, 0,0,0,0,1};
    vecs[5]  = '{0,0,0,0,1,7,0, 0,0,0,1,1};
    vecs[6]  = '{0,0,0,0,1,7,0, 0,0,0,1,1};
    vecs[7]  = '{0,0,0,0,1,7,0, 0,0,0,1,1};
    vecs[8]  = '{0,0,0,0,1,7,0, 1,7,0,1,1};
    vecs[9]  = '{1,7,1,0,1,3,0, 0,0,0,0,1};
    vecs[10] = '{0,0,0,0,1,3,0, 1,7,0,1,1};
    vecs[11] = '{1,1,1,1,1,1,0, 0,0,0,0,1};
    vecs[12] = '{1,2,0,0,1,1,0, 0,0,0,1,1};
    vecs[13] = '{1,3,1,0,1,1,0, 0,0,0,2,1};
    vecs[14] = '{1,4,1,1,0,0,1, 0,0,0,3,1};
    vecs[15] = '{0,0,0,0,0,0,0, 0,0,0,0,1};
    for (int k = 0; k < 10; k++) a_idx[k] = 16 + k;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.ready", int'(br_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].br_v, vecs[i].idx, vecs[i].tk, vecs[i].pr, vecs[i].r_v, vecs[i].idx_r, vecs[i].fl);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_wv, vecs[i].e_idx, vecs[i].e_cor, vecs[i].e_cnt);
      chk($sformatf("vec%0d.ready", i), int'(br_ready), vecs[i].e_rdy);
    end

    // Fill under sustained collisions: starvation bound pops A0 (k=4) and A1 (k=8).
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_head = (k <= 4) ? a_idx[0] : ((k <= 8) ? a_idx[1] : a_idx[2]);
      exp_wv   = (k == 4 || k == 8) ? 1 : 0;
      drive(1, a_idx[k], k % 2, 0, 1, (k == 0) ? 0 : exp_head, 0);
      #1;
      chk_out($sformatf("fill%0d", k), exp_wv, exp_wv ? exp_head : 0,
              exp_wv ? (1 - ((k == 4) ? 0 : 1)) : 0, exp_cnt[k]);
      chk($sformatf("fill%0d.ready", k), int'(br_ready), 1);
    end

    @(negedge clk);
    drive(1, 9, 1, 1, 1, a_idx[2], 0);
    #1;
    chk_out("full", 0, 0, 0, 8);
`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
    chk("full.ready", int'(br_ready), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drop.cnt", int'(drop_cnt), 1);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk_out($sformatf("ddrain%0d", j), 1, (j < 7) ? a_idx[3 + j] : 9,
              (j < 7) ? (1 - ((3 + j) % 2)) : 1, 8 - j);
    end
`else
    chk("full.ready", int'(br_ready), 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_out($sformatf("drain%0d", j), 1, a_idx[2 + j], 1 - ((2 + j) % 2), 8 - j);
    end
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("drained", 0, 0, 0, 0);

    // Async reset in the middle of a drain clears every output immediately.
    @(negedge clk);
    drive(1, 20, 1, 1, 1, 20, 0);
    @(negedge clk);
    drive(1, 21, 0, 0, 1, 20, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("predrain", 1, 20, 1, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 0, 0, 0, 0);
    chk("midreset.ready", int'(br_ready), 0);
`ifdef BP_FE_BHT_UPD_DROP_OLDEST_EN
    chk("midreset.drop", int'(drop_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_out("postreset", 0, 0, 0, 0);
    chk("postreset.ready", int'(br_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
